// File: rtl/ball_pkg.sv
// Shared types and frame-timing constants for the ball pixel pipeline.
package ball_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int VACTIVE  = 480;
    localparam int COMMIT_V = 480;
    localparam int COMMIT_H = 0;
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/ball_pixel_pipe_abs_sq.sv
// Two-stage |a-b|^2: registered absolute difference, then registered square.
module abs_sq (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  a_i,
    input  logic [9:0]  b_i,
    output logic [19:0] sq_o
);

    logic [9:0]  diff_q;
    logic [19:0] sq_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            diff_q <= '0;
            sq_q   <= '0;
        end else begin
            diff_q <= (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
            sq_q   <= diff_q * diff_q;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/ball_pixel_pipe.sv
// Ball/background pixel generator: frame-synchronous position commit and a
// 3-clock colour pipeline with sync/blank delayed to match.
module ball_pixel_pipe
    import ball_pkg::*;
#(
    parameter int          RADIUS = 16,
    parameter logic [23:0] FG_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB = 24'h000080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pos_h_in,
    input  logic [7:0]  pos_v_in,
    input  logic        pos_we,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        blank_n_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        blank_n_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        frame_tick,
    output logic        pos_pending
);

    localparam logic [20:0] R_SQ = 21'(RADIUS * RADIUS);

    logic [7:0] stage_h_q, stage_v_q, act_h_q, act_v_q;
    logic       pending_q, tick_q;
    logic       commit;

    assign commit = (hcount == 11'(COMMIT_H)) && (vcount == 10'(COMMIT_V));

    // A write coinciding with the commit still stages; the commit takes the old stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_h_q <= '0;
            stage_v_q <= '0;
            act_h_q   <= '0;
            act_v_q   <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= commit;
            if (commit && pending_q) begin
                act_h_q <= stage_h_q;
                act_v_q <= stage_v_q;
            end
            if (pos_we) begin
                stage_h_q <= pos_h_in;
                stage_v_q <= pos_v_in;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign frame_tick  = tick_q;
    assign pos_pending = pending_q;

    logic [9:0]  col, cx, cy;
    logic [19:0] dx2, dy2;

    assign col = hcount[10:1];
    assign cx  = {act_h_q[6:0], 3'b000};
    assign cy  = {act_v_q[5:0], 4'b0000};

    abs_sq u_abs_x (.clk(clk), .reset(reset), .a_i(col),    .b_i(cx), .sq_o(dx2));
    abs_sq u_abs_y (.clk(clk), .reset(reset), .a_i(vcount), .b_i(cy), .sq_o(dy2));

    logic [2:0] blank_q, hs_q, vs_q;
    rgb_t       rgb_d, rgb_q;
    logic [20:0] sum;

    always_comb begin
        sum = {1'b0, dx2} + {1'b0, dy2};
        if (!blank_q[1])
            rgb_d = '0;
        else if (sum < R_SQ)
            rgb_d = rgb_t'(FG_RGB);
        else
            rgb_d = rgb_t'(BG_RGB);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q <= 3'b000;
            hs_q    <= 3'b111;
            vs_q    <= 3'b111;
            rgb_q   <= '0;
        end else begin
            blank_q <= {blank_q[1:0], blank_n_in};
            hs_q    <= {hs_q[1:0], hs_in};
            vs_q    <= {vs_q[1:0], vs_in};
            rgb_q   <= rgb_d;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign blank_n_out = blank_q[2];
    assign hs_out      = hs_q[2];
    assign vs_out      = vs_q[2];

endmodule

// File: tb/tb_ball_pixel_pipe.sv
// Scoreboard bench for ball_pixel_pipe: expected pixels queued at drive time,
// popped three clocks later, plus direct checks of reset and commit status.
module tb_ball_pixel_pipe;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000080;
    localparam int          R  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pos_h_in, pos_v_in;
    logic        pos_we;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        blank_n_in, hs_in, vs_in;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        blank_n_out, hs_out, vs_out, frame_tick, pos_pending;

    ball_pixel_pipe dut (
        .clk(clk), .reset(reset),
        .pos_h_in(pos_h_in), .pos_v_in(pos_v_in), .pos_we(pos_we),
        .hcount(hcount), .vcount(vcount),
        .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .blank_n_out(blank_n_out), .hs_out(hs_out), .vs_out(vs_out),
        .frame_tick(frame_tick), .pos_pending(pos_pending)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [23:0] rgb;
        logic        blank;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int m_stage_h, m_stage_v, m_act_h, m_act_v;
    bit m_pending, m_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(int col, int row, int h, int v, bit blank);
        int cx, cy, dx, dy;
        if (!blank) return 24'h0;
        cx = (h * 8) % 1024;
        cy = (v * 16) % 1024;
        dx = (col > cx) ? col - cx : cx - col;
        dy = (row > cy) ? row - cy : cy - row;
        return (dx * dx + dy * dy < R * R) ? FG : BG;
    endfunction

    task automatic set_idle();
        hcount = 11'd1; vcount = 10'd0;
        blank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        pos_we = 1'b0; pos_h_in = '0; pos_v_in = '0;
    endtask

    task automatic model_reset();
        m_stage_h = 0; m_stage_v = 0; m_act_h = 0; m_act_v = 0;
        m_pending = 0; m_tick = 0;
        q.delete();
        // Pipeline holds idle/reset content, which looks identical at the outputs.
        repeat (3) q.push_back('{"idle", 24'h0, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic step(input string tag, input int col, input int row,
                        input bit blank = 1, input bit hs = 1, input bit vs = 1,
                        input bit we = 0, input int ph = 0, input int pv = 0,
                        input bit odd = 0);
        exp_t e;
        bit   commit;
        @(negedge clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            check({e.tag, "/rgb"}, {8'h0, vga_r, vga_g, vga_b}, {8'h0, e.rgb});
            check({e.tag, "/blank"}, 32'(blank_n_out), 32'(e.blank));
            check({e.tag, "/hs"}, 32'(hs_out), 32'(e.hs));
            check({e.tag, "/vs"}, 32'(vs_out), 32'(e.vs));
        end
        check({tag, "/pending"}, 32'(pos_pending), 32'(m_pending));
        check({tag, "/tick"}, 32'(frame_tick), 32'(m_tick));
        hcount = 11'(col * 2 + int'(odd)); vcount = 10'(row);
        blank_n_in = blank; hs_in = hs; vs_in = vs;
        pos_we = we; pos_h_in = 8'(ph); pos_v_in = 8'(pv);
        q.push_back('{tag, model_rgb(col, row, m_act_h, m_act_v, blank), blank, hs, vs});
        commit = (col == 0) && !odd && (row == 480);
        m_tick = commit;
        if (commit && m_pending) begin
            m_act_h = m_stage_h; m_act_v = m_stage_v;
        end
        if (we) begin
            m_stage_h = ph; m_stage_v = pv; m_pending = 1;
        end else if (commit) begin
            m_pending = 0;
        end
    endtask

    task automatic flush();
        repeat (3) step("flush", 600, 500, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (3) @(negedge clk);
        check("rst/rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        check("rst/blank", 32'(blank_n_out), 32'd0);
        check("rst/hs", 32'(hs_out), 32'd1);
        check("rst/vs", 32'(vs_out), 32'd1);
        check("rst/pending", 32'(pos_pending), 32'd0);
        check("rst/tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;
        model_reset();

        // Ball at (0,0): radius boundary along the row and column
        step("p00", 0, 0);
        step("p16_0", 16, 0);
        step("p15_0", 15, 0);
        step("p15_0_odd", 15, 0, .odd(1));
        step("p0_15", 0, 15);
        step("p0_16", 0, 16);
        step("p11_11", 11, 11);
        step("p12_12", 12, 12);

        // Staged write mid-frame must not move the ball
        step("we40_15", 5, 100, .we(1), .ph(40), .pv(15));
        step("pre320", 320, 240);
        step("pre0", 0, 0);
        step("commit1", 0, 480, 0);
        step("post_tick", 1, 480, 0);
        step("p320_240", 320, 240);
        step("p336_240", 336, 240);
        step("p335_240", 335, 240);
        step("p320_255", 320, 255);
        step("p320_256", 320, 256);
        step("old00", 0, 0);

        // Commit with nothing pending keeps the position
        step("commit_idle", 0, 480, 0);
        step("keep320", 320, 240);

        // Write coinciding with the commit stages for the following frame
        step("we20_5", 50, 10, .we(1), .ph(20), .pv(5));
        step("commit_we", 0, 480, 0, .we(1), .ph(10), .pv(15));
        step("after_cw", 2, 480, 0);
        step("p160_80", 160, 80);
        step("p80_240_pre", 80, 240);
        step("commit3", 0, 480, 0);
        step("after_c3", 3, 480, 0);
        step("p80_240", 80, 240);
        step("p160_80_old", 160, 80);
        step("p64_240", 64, 240);
        step("p65_240", 65, 240);

        // Blanking forces black over the ball
        step("blank_ball", 80, 240, 0);
        step("blank_edge", 81, 240, 0, 0, 1);

        // Sync/blank delay across one full line
        for (int i = 0; i < 1600; i++) begin
            step("line", i / 2, 300, (i < 1280) ^ ($urandom_range(0, 15) == 0),
                 !(i >= 1312 && i < 1504), 1'($urandom_range(0, 1)), 0, 0, 0, 1'(i % 2));
        end
        flush();

        // Asynchronous reset mid-line with a pending position and a ball in flight
        step("we50", 10, 20, .we(1), .ph(50), .pv(3));
        step("fly0", 80, 240);
        step("fly1", 80, 241);
        step("fly2", 79, 240);
        @(posedge clk);
        #2;
        reset = 1'b1;
        set_idle();
        #1;
        check("mid_rst/rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        check("mid_rst/blank", 32'(blank_n_out), 32'd0);
        check("mid_rst/hs", 32'(hs_out), 32'd1);
        check("mid_rst/vs", 32'(vs_out), 32'd1);
        check("mid_rst/pending", 32'(pos_pending), 32'd0);
        check("mid_rst/tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        step("rst_p00", 0, 0);
        step("rst_p80", 80, 240);
        step("rst_p400", 400, 48);
        step("rst_commit", 0, 480, 0);
        step("rst_p00b", 0, 0);
        flush();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ball_pixel_pipe.md
Name: ball_pixel_pipe

Overview:
- Pixel-generation stage between the VGA timing counters and the VGA DAC pins.
- Takes raw hcount/vcount/sync/blank from the counter block plus ball-position register writes from the bus slave.
- Double-buffers the position so it only changes at a frame boundary.
- Computes ball/background colour in a 3-stage pipeline, delaying sync/blank to stay aligned with the colour.

Parameters:
- RADIUS, 16, ball radius in pixels; ball when dx²+dy² < RADIUS².
- FG_RGB, 24'hFFFFFF, ball colour {R,G,B}.
- BG_RGB, 24'h000080, background colour {R,G,B}.

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  asynchronous, active-high
- pos_h_in  in  8  horizontal position; centre column = pos_h_in*8
- pos_v_in  in  8  vertical position; centre row = (pos_v_in*16) mod 1024
- pos_we  in  1  single-cycle strobe; stage pos_h_in/pos_v_in
- hcount  in  11  counter value; hcount[10:1] = pixel column
- vcount  in  10  pixel row, 0..524
- blank_n_in  in  1  active-video flag from counters
- hs_in  in  1  hsync, active-low
- vs_in  in  1  vsync, active-low
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- blank_n_out  out  1  blank_n_in delayed 3 clocks
- hs_out  out  1  hs_in delayed 3 clocks
- vs_out  out  1  vs_in delayed 3 clocks
- frame_tick  out  1  one-cycle pulse on every commit event
- pos_pending  out  1  staged position not yet committed

Behaviour:
- Reset (async, immediate, also mid-frame):
  - vga_r/g/b = 0, blank_n_out = 0, hs_out = 1, vs_out = 1.
  - frame_tick = 0, pos_pending = 0.
  - Staged and active positions = 0.
  - All pipeline registers cleared.
- Staging:
  - On pos_we: stage_h <= pos_h_in, stage_v <= pos_v_in, pending <= 1.
  - Back-to-back writes: the last write wins.
- Commit event: hcount == 0 && vcount == 480 (first clock of vblank).
  - frame_tick = 1 for that cycle.
  - If pending: active <= stage, pending <= 0.
  - If not pending: active position unchanged.
- pos_we in the same cycle as the commit event:
  - Commit takes the previously staged value.
  - The new value is staged and pending stays 1, so it commits next frame.
- Pipeline (3 clocks, fixed latency, no stalls):
  - S1: col = hcount[10:1]; cx = {active_h,3'b0} (10b); cy = {active_v,4'b0}[9:0].
  - S1 continued: dx = |col − cx|, dy = |vcount − cy|, both unsigned 10b; register blank/hs/vs.
  - S2: dx2 = dx*dx, dy2 = dy*dy (20b each); register.
  - S3: sum = dx2 + dy2 (21b, no overflow); ball = sum < RADIUS*RADIUS.
  - S3 output when blank_n (S2 copy) = 1: rgb = ball ? FG_RGB : BG_RGB.
  - S3 output when blank_n (S2 copy) = 0: rgb = 0.
  - S3 also registers blank_n_out/hs_out/vs_out.
- Output alignment: output at clock n+3 corresponds to inputs at clock n.
- Position changes never take effect mid-frame; active values are stable from vcount 480 through the next frame's active region.
- Edge handling: ball may straddle screen edges (cx = 0 gives a half circle). No wrap in dx/dy; absolute difference only.

Decomposition:
- Package ball_pkg:
  - typedef rgb_t (24b packed {r,g,b}).
  - Constants VACTIVE = 480, COMMIT_V = 480, COMMIT_H = 0, PIPE_LAT = 3.
- One sub-module, abs_sq:
  - Registered |a−b| then registered square, 10b in / 20b out, 2-clock latency.
  - Instantiated twice (x and y).

Test Plan:
- Reset then idle, pos 0,0; sweep one frame:
  - pixel (col 0,row 0) → FG at 3-clock delay.
  - (col 16,row 0) → BG (256 not < 256).
  - (col 15,row 0) → FG.
- pos_we with h=40,v=15 at vcount 100:
  - pending = 1; pixels around (320,240) stay BG for the rest of the frame.
  - At vcount 480/hcount 0: frame_tick pulses, pending = 0.
  - Next frame: (320,240) = FG, (336,240) = BG.
- pos_we asserted exactly on the commit cycle with h=10:
  - Active keeps the prior stage, pending stays 1.
  - Commits at the following frame's tick.
- blank_n_in = 0 during a ball pixel → rgb = 0.
- hs/vs/blank_n out equal the inputs delayed exactly 3 clocks across a full line.
- Reset asserted mid-line with pending = 1:
  - Outputs drop to reset values in the same cycle; pending = 0, active = 0.
  - After release, the ball renders at (0,0).
